alarm_sequencer: RTL
====================

# alarm_sequencer

Controller that sequences the metal-detector alarm output from a detect input and software-programmed timing registers. Sits between the sensor front end and the alarm_timer AXI4-Lite register bank: the slave registers feed the `*_ticks` and `repeat_cnt` inputs, and status outputs are read back through the same bank. It paces the buzzer/LED in on/off bursts, supports software acknowledge, and enforces a hold-off after each alarm.

## Interface
Parameters:
- CNT_W, 32, width of on/off/hold-off tick counters
- REP_W, 8, width of repeat count
- EVT_W, 16, width of accepted-event counter

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high reset
- enable  in  1  sequencer enable; low forces IDLE
- detect  in  1  asynchronous detect level from sensor front end
- ack  in  1  single-cycle software acknowledge; ends the current alarm
- on_ticks  in  CNT_W  alarm-on duration in cycles
- off_ticks  in  CNT_W  gap duration in cycles
- repeat_cnt  in  REP_W  number of ON pulses; 0 = until ack
- holdoff_ticks  in  CNT_W  dead time after alarm
- alarm_out  out  1  registered buzzer/LED drive
- busy  out  1  high in any state other than IDLE
- state_o  out  2  IDLE=0, ON=1, OFF=2, HOLDOFF=3
- event_count  out  EVT_W  accepted triggers, saturating

## Operation
- detect passes through a 2-flop synchronizer (s1, s2) plus a delay flop s3; trigger = s2 & ~s3 (rising edge only).
- On trigger in IDLE with enable=1: latch on/off/repeat/holdoff into shadow registers, load tick counter and pulse counter, enter ON, increment event_count (holds at all-ones).
- ON lasts max(on_ticks,1) cycles. On expiry: if pulses done (latched repeat ≠ 0 and pulse counter reaches latched repeat) → HOLDOFF, else → OFF.
- OFF lasts max(off_ticks,1) cycles, then → ON, pulse counter +1.
- HOLDOFF lasts max(holdoff_ticks,1) cycles, then → IDLE. Triggers in HOLDOFF are ignored and not counted.
- ack in ON or OFF → HOLDOFF on the next edge. ack in IDLE/HOLDOFF has no effect.
- enable=0 in any state → IDLE on the next edge; counters cleared, event_count kept.
- Register inputs changing mid-alarm have no effect until the next trigger (shadow copy).
- Priority, highest first: reset, enable=0, ack, counter expiry, trigger.
- Tick counter is a CNT_W down-counter: loaded with value−1 (0 treated as 1); expiry when it reads 0. No wrap-around.

## Timing
- Reset values: alarm_out=0, busy=0, state_o=0, event_count=0, s1/s2/s3=0, all counters 0.
- alarm_out = registered (state==ON); it changes on the same edge as state.
- detect first sampled high at edge k → state ON and alarm_out=1 after edge k+2 (if enable=1 and IDLE).
- ON of N cycles: alarm_out high for exactly N clock cycles; OFF of M cycles: low for exactly M.
- ack sampled at edge j → alarm_out=0 and state HOLDOFF after edge j.
- Reset asserted mid-alarm → all outputs at reset values after that edge.

## Configuration
- ALARM_SEQ_RETRIGGER_EN defined: trigger in ON or OFF reloads the shadow registers, restarts the pulse counter at 1, enters ON (from OFF) or restarts the ON counter (from ON), and increments event_count. ack in the same cycle wins.
- Not defined: triggers in ON/OFF are ignored and not counted.

## Test plan
- on=3, off=2, repeat=2, holdoff=4, detect rises → alarm_out pattern 1,1,1,0,0,1,1,1 starting edge k+2; then HOLDOFF 4 cycles; IDLE; event_count=1.
- repeat=0, on=1, off=1 → alarm toggles indefinitely; ack after 10 cycles → alarm_out=0 next edge, state_o=3, then IDLE after holdoff.
- enable dropped mid-ON → state_o=0, alarm_out=0, busy=0 next edge; event_count unchanged.
- Second detect edge during OFF: without macro → pattern unchanged, event_count=1; with ALARM_SEQ_RETRIGGER_EN → ON restarts next edge, event_count=2.
- on_ticks/off_ticks/holdoff=0 → each phase lasts 1 cycle; changing on_ticks mid-alarm does not alter the current burst.
- EVT_W=2, 5 full alarms → event_count saturates at 3; reset mid-ON → all outputs 0 after that edge.

Source files
------------

// File: rtl/alarm_sequencer.sv
// alarm_sequencer: paces alarm_out in on/off bursts after a synchronized rising edge of detect.
// Optional build macro ALARM_SEQ_RETRIGGER_EN: a trigger during ON/OFF restarts the burst.
module alarm_sequencer #(
    parameter int unsigned CNT_W = 32,
    parameter int unsigned REP_W = 8,
    parameter int unsigned EVT_W = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic             detect,
    input  logic             ack,
    input  logic [CNT_W-1:0] on_ticks,
    input  logic [CNT_W-1:0] off_ticks,
    input  logic [REP_W-1:0] repeat_cnt,
    input  logic [CNT_W-1:0] holdoff_ticks,
    output logic             alarm_out,
    output logic             busy,
    output logic [1:0]       state_o,
    output logic [EVT_W-1:0] event_count
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ON      = 2'd1,
        OFF     = 2'd2,
        HOLDOFF = 2'd3
    } state_t;

    state_t           state;
    logic             s1, s2, s3;
    logic             trigger, retrig_ok, start, tick_zero, pulses_done;
    logic [CNT_W-1:0] tick_cnt, sh_on, sh_off, sh_hold;
    logic [REP_W-1:0] pulse_cnt, sh_rep;

    // A programmed duration of 0 behaves as 1 cycle.
    function automatic logic [CNT_W-1:0] load_val(input logic [CNT_W-1:0] t);
        return (t == '0) ? '0 : t - CNT_W'(1);
    endfunction

    assign trigger     = s2 & ~s3;
    assign tick_zero   = (tick_cnt == '0);
    assign pulses_done = (sh_rep != '0) && (pulse_cnt == sh_rep);

`ifdef ALARM_SEQ_RETRIGGER_EN
    // ack and phase expiry both outrank a retrigger.
    assign retrig_ok = ((state == ON) || (state == OFF)) && !ack && !tick_zero;
`else
    assign retrig_ok = 1'b0;
`endif

    assign start   = trigger && ((state == IDLE) || retrig_ok);
    assign state_o = state;

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= IDLE;
            s1          <= 1'b0;
            s2          <= 1'b0;
            s3          <= 1'b0;
            alarm_out   <= 1'b0;
            busy        <= 1'b0;
            event_count <= '0;
            tick_cnt    <= '0;
            pulse_cnt   <= '0;
            sh_on       <= '0;
            sh_off      <= '0;
            sh_hold     <= '0;
            sh_rep      <= '0;
        end else begin
            s1 <= detect;
            s2 <= s1;
            s3 <= s2;
            if (!enable) begin
                state     <= IDLE;
                alarm_out <= 1'b0;
                busy      <= 1'b0;
                tick_cnt  <= '0;
                pulse_cnt <= '0;
            end else if (start) begin
                sh_on     <= on_ticks;
                sh_off    <= off_ticks;
                sh_rep    <= repeat_cnt;
                sh_hold   <= holdoff_ticks;
                tick_cnt  <= load_val(on_ticks);
                pulse_cnt <= REP_W'(1);
                state     <= ON;
                alarm_out <= 1'b1;
                busy      <= 1'b1;
                if (event_count != '1) begin
                    event_count <= event_count + EVT_W'(1);
                end
            end else begin
                case (state)
                    ON: begin
                        if (ack || (tick_zero && pulses_done)) begin
                            state     <= HOLDOFF;
                            alarm_out <= 1'b0;
                            tick_cnt  <= load_val(sh_hold);
                        end else if (tick_zero) begin
                            state     <= OFF;
                            alarm_out <= 1'b0;
                            tick_cnt  <= load_val(sh_off);
                        end else begin
                            tick_cnt <= tick_cnt - CNT_W'(1);
                        end
                    end
                    OFF: begin
                        if (ack) begin
                            state    <= HOLDOFF;
                            tick_cnt <= load_val(sh_hold);
                        end else if (tick_zero) begin
                            state     <= ON;
                            alarm_out <= 1'b1;
                            tick_cnt  <= load_val(sh_on);
                            pulse_cnt <= pulse_cnt + REP_W'(1);
                        end else begin
                            tick_cnt <= tick_cnt - CNT_W'(1);
                        end
                    end
                    HOLDOFF: begin
                        if (tick_zero) begin
                            state     <= IDLE;
                            busy      <= 1'b0;
                            pulse_cnt <= '0;
                        end else begin
                            tick_cnt <= tick_cnt - CNT_W'(1);
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

endmodule
